// File: rtl/four_12_12_st2_tap_arb_pkg.sv
// rtl/four_12_12_st2_tap_arb_pkg.sv - shared defaults and state types for the tap memory arbiter
package four_12_12_st2_tap_arb_pkg;

  localparam int TAPS_DEF         = 12;
  localparam int PHASES_DEF       = 10;
  localparam int DRAIN_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_UPD   = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_FWD = 1'b0,
    OWN_UPD = 1'b1
  } owner_e;

endpackage

// File: rtl/four_12_12_wrap_counter.sv
// rtl/four_12_12_wrap_counter.sv - enabled counter that returns to zero after reaching wrap_val
module four_12_12_wrap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] wrap_val,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q >= wrap_val) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/four_12_12_st2_tap_arb.sv
// rtl/four_12_12_st2_tap_arb.sv - non-preemptive burst arbiter between forward and update passes over tap memory
module four_12_12_st2_tap_arb
  import four_12_12_st2_tap_arb_pkg::*;
#(
  parameter int TAPS         = TAPS_DEF,
  parameter int PHASES       = PHASES_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fwd_req,
  input  logic       upd_req,
  input  logic       upd_urgent,
  input  logic [3:0] load_length,
  output logic       fwd_gnt,
  output logic       upd_gnt,
  output logic [3:0] mem_addr,
  output logic [3:0] mem_phase,
  output logic       mem_we,
  output logic       burst_last,
  output logic       busy
);

  localparam logic [3:0] LEN_MAX    = 4'(TAPS - 1);
  localparam logic [3:0] PHASE_WRAP = 4'(PHASES - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  arb_state_e state_q, state_d;
  owner_e     last_owner_q, last_owner_d;
  logic [3:0] len_q, len_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] drain_q, drain_d;

  logic       go_fwd, go_upd;
  logic [3:0] len_sat;
  logic       beat_last;
  logic       fwd_done, upd_done;
  logic [3:0] fwd_phase, upd_phase;

  assign len_sat   = (load_length > LEN_MAX) ? LEN_MAX : load_length;
  assign beat_last = (addr_q == len_q);
  assign fwd_done  = (state_q == ST_FWD) && beat_last;
  assign upd_done  = (state_q == ST_UPD) && beat_last;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    len_d        = len_q;
    addr_d       = addr_q;
    drain_d      = drain_q;
    go_fwd       = 1'b0;
    go_upd       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Urgent updates bypass fairness; otherwise a tie goes to whoever waited last.
        if (upd_req && upd_urgent) begin
          go_upd = 1'b1;
        end else if (fwd_req && upd_req) begin
          go_fwd = (last_owner_q == OWN_UPD);
          go_upd = (last_owner_q == OWN_FWD);
        end else begin
          go_fwd = fwd_req;
          go_upd = upd_req && !fwd_req;
        end
        if (go_fwd || go_upd) begin
          state_d      = go_fwd ? ST_FWD : ST_UPD;
          last_owner_d = go_fwd ? OWN_FWD : OWN_UPD;
          len_d        = len_sat;
          addr_d       = '0;
        end
      end
      ST_FWD, ST_UPD: begin
        if (beat_last) begin
          addr_d  = '0;
          state_d = (state_q == ST_FWD) ? ST_IDLE : ST_DRAIN;
          drain_d = DRAIN_LAST;
        end else begin
          addr_d = addr_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_UPD;
      len_q        <= '0;
      addr_q       <= '0;
      drain_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      drain_q      <= drain_d;
    end
  end

  four_12_12_wrap_counter #(.W(4)) u_fwd_phase (
    .clk      (clk),
    .reset    (reset),
    .en       (fwd_done),
    .wrap_val (PHASE_WRAP),
    .count    (fwd_phase)
  );

  four_12_12_wrap_counter #(.W(4)) u_upd_phase (
    .clk      (clk),
    .reset    (reset),
    .en       (upd_done),
    .wrap_val (PHASE_WRAP),
    .count    (upd_phase)
  );

  assign fwd_gnt    = (state_q == ST_FWD);
  assign upd_gnt    = (state_q == ST_UPD);
  assign mem_we     = upd_gnt;
  assign busy       = (state_q != ST_IDLE);
  assign mem_addr   = (fwd_gnt || upd_gnt) ? addr_q : 4'd0;
  assign burst_last = (fwd_gnt || upd_gnt) && beat_last;
  assign mem_phase  = upd_gnt ? upd_phase : fwd_phase;

endmodule
